// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM states and stage indices for the pipeline controller
package pipe_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    localparam int PC_IDX     = 0;
    localparam int IF_ID_IDX  = 1;
    localparam int ID_EX_IDX  = 2;
    localparam int EX_MEM_IDX = 3;
    localparam int MEM_WB_IDX = 4;
endpackage

// File: rtl/prio_enc.sv
// prio_enc: index of the highest set bit, plus an any-set flag
module prio_enc #(
    parameter int W = 5
) (
    input  logic [W-1:0]         req,
    output logic [$clog2(W)-1:0] idx,
    output logic                 valid
);
    localparam int IW = $clog2(W);
    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++)
            if (req[i]) idx = IW'(i);
    end
    assign valid = |req;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/bubble/flush resolution with debug drain-halt,
// stall watchdog and stall-cycle counter
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES    = 5,
    parameter int MAX_STALL = 64,
    parameter int CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic [STAGES-1:0]         stall_req,
    input  logic                      flush_req,
    input  logic [$clog2(STAGES)-1:0] flush_stage,
    input  logic                      halt_req,
    output logic [STAGES-1:0]         stall,
    output logic [STAGES-1:0]         bubble,
    output logic                      halt_ack,
    output logic                      stall_timeout,
    output logic [CNT_W-1:0]          stall_cycles
);
    localparam int IW = $clog2(STAGES);
    localparam int WW = $clog2(MAX_STALL + 1);
    state_t            state, state_n;
    logic [IW-1:0]     k, tgt, pend_j, dcnt, dcnt_n;
    logic [WW-1:0]     wd;
    logic [STAGES-1:0] stall_c, bub_c;
    logic              any, pend_v, eff, stalled;
    prio_enc #(.W(STAGES)) u_enc (.req(stall_req), .idx(k), .valid(any));
    assign stalled  = any || !rdy;
    assign tgt      = flush_req ? flush_stage : pend_j;
    // A flush lands only once every stalled register sits strictly below its target
    assign eff      = rdy && state != HALTED && (flush_req || pend_v) && (!any || k < tgt);
    assign halt_ack = state == HALTED;
    always_comb begin
        stall_c = '0;
        bub_c   = '0;
        for (int i = 0; i < STAGES; i++) begin
            stall_c[i] = any && IW'(i) <= k;
            if (i > 0) bub_c[i] = (any && IW'(i - 1) == k) || (eff && IW'(i) <= tgt);
        end
        if (eff) stall_c[PC_IDX] = 1'b0;
        if (state == DRAIN) begin
            stall_c[PC_IDX]   = 1'b1;
            bub_c[IF_ID_IDX]  = 1'b1;
        end
        if (state == HALTED || !rdy) begin
            stall_c = '1;
            bub_c   = '0;
        end
        stall  = rst ? stall_c : '0;
        bubble = rst ? (bub_c & ~stall_c) : '0;
    end
    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        case (state)
            RUN:    if (halt_req) begin
                        state_n = DRAIN;
                        dcnt_n  = '0;
                    end
            DRAIN:  if (!halt_req) begin
                        state_n = RUN;
                        dcnt_n  = '0;
                    end else if (!any && rdy) begin
                        state_n = dcnt == IW'(STAGES - 2) ? HALTED : DRAIN;
                        dcnt_n  = dcnt == IW'(STAGES - 2) ? '0 : dcnt + 1'b1;
                    end
            HALTED: if (!halt_req) state_n = RUN;
            default: state_n = RUN;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            dcnt          <= '0;
            pend_v        <= 1'b0;
            pend_j        <= '0;
            wd            <= '0;
            stall_timeout <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
            if (flush_req && !eff) begin
                pend_v <= 1'b1;
                pend_j <= flush_stage;
            end else if (eff) begin
                pend_v <= 1'b0;
            end
            wd            <= !stalled ? '0 : (wd == WW'(MAX_STALL) ? wd : wd + 1'b1);
            stall_timeout <= stalled && wd == WW'(MAX_STALL - 1);
            if (|stall_c) stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table plus hand sequences for flush, halt,
// watchdog, counter and reset behaviour
module tb_pipe_ctrl;
    logic        clk = 0, rst = 0, rdy = 1, flush_req = 0, halt_req = 0;
    logic [4:0]  stall_req = '0;
    logic [2:0]  flush_stage = '0;
    logic [4:0]  stall, bubble;
    logic        halt_ack, stall_timeout;
    logic [31:0] stall_cycles;
    int          total = 0, passed = 0;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall_req(stall_req),
        .flush_req(flush_req), .flush_stage(flush_stage), .halt_req(halt_req),
        .stall(stall), .bubble(bubble), .halt_ack(halt_ack),
        .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [4:0] sr;
        logic       f;
        logic [2:0] j;
        logic [4:0] es;
        logic [4:0] eb;
    } vec_t;
    vec_t tv[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic idle();
        rdy = 1; stall_req = '0; flush_req = 0; flush_stage = '0; halt_req = 0;
    endtask

    initial begin
        int pulses, first;
        tv[0]  = '{1'b1, 5'b01000, 1'b0, 3'd0, 5'b01111, 5'b10000};
        tv[1]  = '{1'b1, 5'b00001, 1'b0, 3'd0, 5'b00001, 5'b00010};
        tv[2]  = '{1'b1, 5'b00000, 1'b0, 3'd0, 5'b00000, 5'b00000};
        tv[3]  = '{1'b1, 5'b10000, 1'b0, 3'd0, 5'b11111, 5'b00000};
        tv[4]  = '{1'b1, 5'b00101, 1'b0, 3'd0, 5'b00111, 5'b01000};
        tv[5]  = '{1'b0, 5'b00000, 1'b0, 3'd0, 5'b11111, 5'b00000};
        tv[6]  = '{1'b0, 5'b01010, 1'b0, 3'd0, 5'b11111, 5'b00000};
        tv[7]  = '{1'b1, 5'b00000, 1'b1, 3'd2, 5'b00000, 5'b00110};
        tv[8]  = '{1'b1, 5'b00001, 1'b1, 3'd4, 5'b00000, 5'b11110};
        tv[9]  = '{1'b1, 5'b00010, 1'b1, 3'd3, 5'b00010, 5'b01100};
        tv[10] = '{1'b1, 5'b00000, 1'b1, 3'd1, 5'b00000, 5'b00010};

        idle();
        do_reset();
        @(negedge clk);
        chk("reset_stall", 32'(stall), 0);
        chk("reset_bubble", 32'(bubble), 0);
        chk("reset_ack", 32'(halt_ack), 0);
        chk("reset_timeout", 32'(stall_timeout), 0);
        chk("reset_cycles", stall_cycles, 0);

        // stall-cycle counter
        @(posedge clk); #1 stall_req = 5'b00001;
        repeat (10) @(posedge clk);
        #1 stall_req = '0;
        @(negedge clk);
        chk("stall_cycles_10", stall_cycles, 10);

        foreach (tv[n]) begin
            @(posedge clk); #1;
            rdy = tv[n].r; stall_req = tv[n].sr; flush_req = tv[n].f; flush_stage = tv[n].j;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", n), 32'(stall), 32'(tv[n].es));
            chk($sformatf("vec%0d_bubble", n), 32'(bubble), 32'(tv[n].eb));
        end
        @(posedge clk); #1 idle();

        // deferred flush
        @(posedge clk); #1 flush_req = 1; flush_stage = 3'd2; stall_req = 5'b01000;
        @(negedge clk);
        chk("defer_c0_stall", 32'(stall), 32'(5'b01111));
        chk("defer_c0_bubble", 32'(bubble), 32'(5'b10000));
        @(posedge clk); #1 flush_req = 0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("defer_c%0d_bubble", c), 32'(bubble), 32'(5'b10000));
            @(posedge clk); #1;
        end
        stall_req = '0;
        @(negedge clk);
        chk("defer_apply_bubble", 32'(bubble), 32'(5'b00110));
        chk("defer_apply_stall", 32'(stall), 0);
        @(posedge clk); @(negedge clk);
        chk("defer_cleared", 32'(bubble), 0);

        // watchdog under rdy=0
        do_reset();
        @(posedge clk); #1 rdy = 0;
        pulses = 0; first = 0;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk); #1;
            if (stall_timeout) begin
                pulses++;
                if (first == 0) first = n;
            end
        end
        rdy = 1;
        chk("wd_pulse_count", 32'(pulses), 1);
        chk("wd_pulse_cycle", 32'(first), 64);

        // halt with no stalls
        do_reset();
        @(posedge clk); #1 halt_req = 1;
        @(posedge clk); @(negedge clk);
        chk("drain_stall", 32'(stall), 32'(5'b00001));
        chk("drain_bubble", 32'(bubble), 32'(5'b00010));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain_no_ack_yet", 32'(halt_ack), 0);
        @(posedge clk); @(negedge clk);
        chk("halt_ack", 32'(halt_ack), 1);
        chk("halt_stall", 32'(stall), 32'(5'b11111));
        chk("halt_bubble", 32'(bubble), 0);
        @(posedge clk); #1 halt_req = 0;
        @(posedge clk); @(negedge clk);
        chk("resume_ack", 32'(halt_ack), 0);
        chk("resume_stall", 32'(stall), 0);

        // halt with one stalled cycle mid-drain
        @(posedge clk); #1 halt_req = 1;
        @(posedge clk);
        @(posedge clk); #1 stall_req = 5'b00001;
        @(posedge clk); #1 stall_req = '0;
        @(posedge clk);
        @(posedge clk); @(negedge clk);
        chk("drain_stalled_no_ack", 32'(halt_ack), 0);
        @(posedge clk); @(negedge clk);
        chk("drain_stalled_ack", 32'(halt_ack), 1);
        @(posedge clk); #1 halt_req = 0;
        @(posedge clk); @(negedge clk);
        chk("resume2_ack", 32'(halt_ack), 0);

        // reset during DRAIN with a pending flush
        @(posedge clk); #1 halt_req = 1;
        @(posedge clk); @(posedge clk); #1 flush_req = 1; flush_stage = 3'd2; stall_req = 5'b01000;
        @(posedge clk); #1 flush_req = 0;
        @(negedge clk); stall_req = '0;
        #1 rst = 0;
        #2;
        chk("rst_async_stall", 32'(stall), 0);
        chk("rst_async_cycles", stall_cycles, 0);
        chk("rst_async_ack", 32'(halt_ack), 0);
        rst = 1;
        #1;
        chk("rst_fsm_run_stall", 32'(stall), 0);
        chk("rst_pending_cleared", 32'(bubble), 0);
        halt_req = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
